// File: rtl/uart_rx_if.sv
// Serial receive bundle for uart_rx: raw line in, received byte and status strobes out.
// o_RX_DV, o_RX_Frame_Err and o_RX_Parity_Err are one-cycle strobes with no ready: the consumer must capture o_RX_Byte in the cycle o_RX_DV is high.
interface uart_rx_if;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_RX_Frame_Err;
  logic       o_RX_Parity_Err;

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err, o_RX_Parity_Err
  );

  modport master (
    output i_RX_Serial,
    input  o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err, o_RX_Parity_Err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a 2-flop line synchronizer.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  uart_rx_if.slave   rx,
  output logic [2:0] dbg_state
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    RX_START_BIT  = 3'd1,
    RX_DATA_BITS  = 3'd2,
    RX_PARITY_BIT = 3'd3,
    RX_STOP_BIT   = 3'd4,
    CLEANUP       = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    RX_START_BIT  = 3'd1,
    RX_DATA_BITS  = 3'd2,
    RX_STOP_BIT   = 3'd4,
    CLEANUP       = 3'd5
  } state_t;
`endif

  state_t     state;
  logic       sync1, sync2;
  logic [7:0] count;
  logic [2:0] index;
  logic [7:0] data_buf;
  logic [7:0] byte_reg;
  logic       dv, active, ferr;
`ifdef UART_RX_PARITY_EN
  logic       parity_bit;
  logic       perr;
  logic       parity_bad;
  assign parity_bad = ^{data_buf, parity_bit};
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= IDLE;
      count      <= 8'd0;
      index      <= 3'd0;
      data_buf   <= 8'd0;
      byte_reg   <= 8'd0;
      dv         <= 1'b0;
      active     <= 1'b0;
      ferr       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      perr       <= 1'b0;
`endif
    end else begin
      sync1 <= rx.i_RX_Serial;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          count <= 8'd0;
          index <= 3'd0;
          if (!sync2) begin
            state  <= RX_START_BIT;
            active <= 1'b1;
          end
        end
        RX_START_BIT: begin
          if (count == HALF) begin
            count <= 8'd0;
            if (!sync2) begin
              state <= RX_DATA_BITS;
            end else begin
              // Start bit gone high at mid-bit: treat as noise.
              state  <= IDLE;
              active <= 1'b0;
            end
          end else begin
            count <= count + 8'd1;
          end
        end
        RX_DATA_BITS: begin
          if (count == LAST) begin
            count           <= 8'd0;
            data_buf[index] <= sync2;
            if (index == 3'd7) begin
              index <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state <= RX_PARITY_BIT;
`else
              state <= RX_STOP_BIT;
`endif
            end else begin
              index <= index + 3'd1;
            end
          end else begin
            count <= count + 8'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY_BIT: begin
          if (count == LAST) begin
            count      <= 8'd0;
            parity_bit <= sync2;
            state      <= RX_STOP_BIT;
          end else begin
            count <= count + 8'd1;
          end
        end
`endif
        RX_STOP_BIT: begin
          if (count == LAST) begin
            count  <= 8'd0;
            state  <= CLEANUP;
            active <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr <= parity_bad;
            if (sync2 && !parity_bad) begin
`else
            if (sync2) begin
`endif
              dv       <= 1'b1;
              byte_reg <= data_buf;
            end
            ferr <= ~sync2;
          end else begin
            count <= count + 8'd1;
          end
        end
        CLEANUP: begin
          dv    <= 1'b0;
          ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
          perr  <= 1'b0;
`endif
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          count  <= 8'd0;
          index  <= 3'd0;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign rx.o_RX_DV         = dv;
  assign rx.o_RX_Byte       = byte_reg;
  assign rx.o_RX_Active     = active;
  assign rx.o_RX_Frame_Err  = ferr;
`ifdef UART_RX_PARITY_EN
  assign rx.o_RX_Parity_Err = perr;
`else
  assign rx.o_RX_Parity_Err = 1'b0;
`endif
  assign dbg_state          = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8 with an expected-byte queue checked on every DV strobe.
module tb_uart_rx;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT = PAR ? 86 : 78;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  uart_rx_if  rx();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock  (clk),
    .i_Rst_n  (rst_n),
    .rx       (rx),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_dv_cyc = 0;
  int dv_hi = 0;
  int ferr_hi = 0;
  int perr_hi = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx.o_RX_DV === 1'b1) begin
      dv_hi++;
      last_dv_cyc = cyc;
      if (exp_q.size() == 0) check("dv_unexpected", 32'd1, 32'd0);
      else check("dv_byte", {24'd0, rx.o_RX_Byte}, {24'd0, exp_q.pop_front()});
    end
    if (rx.o_RX_Frame_Err === 1'b1) ferr_hi++;
    if (rx.o_RX_Parity_Err === 1'b1) perr_hi++;
  end

  // Drives the first n bits of a frame; each bit lasts CPB cycles starting just after a rising edge.
  task automatic send_bits(input logic [7:0] d, input logic par, input logic stop, input int n);
    logic [10:0] bits;
    int len;
    if (PAR) begin
      bits = {stop, par, d, 1'b0};
      len  = 11;
    end else begin
      bits = {1'b0, stop, d, 1'b0};
      len  = 10;
    end
    start_cyc = cyc;
    for (int i = 0; i < len && i < n; i++) begin
      rx.i_RX_Serial = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx.i_RX_Serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int dv0, ferr0;

  initial begin
    rst_n = 1'b0;
    rx.i_RX_Serial = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dv", {31'd0, rx.o_RX_DV}, 32'd0);
    check("rst_byte", {24'd0, rx.o_RX_Byte}, 32'd0);
    check("rst_active", {31'd0, rx.o_RX_Active}, 32'd0);
    check("rst_ferr", {31'd0, rx.o_RX_Frame_Err}, 32'd0);
    check("rst_perr", {31'd0, rx.o_RX_Parity_Err}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    // 0xA5: single DV at edge 78 (86 with parity)
    dv0 = dv_hi;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 1'b0, 1'b1, 11);
    check("a5_dv_count", dv_hi - dv0, 1);
    check("a5_latency", last_dv_cyc - start_cyc - 1, LAT);
    check("a5_byte", {24'd0, rx.o_RX_Byte}, 32'hA5);
    check("a5_ferr", ferr_hi, 0);
    check("a5_active", {31'd0, rx.o_RX_Active}, 32'd0);

    // Back-to-back 0x00 then 0xFF with one stop bit each
    idle(3);
    dv0 = dv_hi;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_bits(8'h00, 1'b0, 1'b1, 11);
    send_bits(8'hFF, 1'b0, 1'b1, 11);
    idle(10);
    check("b2b_dv_count", dv_hi - dv0, 2);
    check("b2b_byte", {24'd0, rx.o_RX_Byte}, 32'hFF);
    check("b2b_queue", exp_q.size(), 0);

    // Two-cycle low glitch on the idle line
    dv0 = dv_hi;
    ferr0 = ferr_hi;
    rx.i_RX_Serial = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx.i_RX_Serial = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("glitch_active_hi", {31'd0, rx.o_RX_Active}, 32'd1);
    idle(10);
    check("glitch_active_lo", {31'd0, rx.o_RX_Active}, 32'd0);
    check("glitch_state", {29'd0, dbg_state}, 32'd0);
    check("glitch_dv", dv_hi - dv0, 0);
    check("glitch_ferr", ferr_hi - ferr0, 0);
    check("glitch_perr", perr_hi, 0);

    // 0x3C with stop bit low, then line held low
    idle(5);
    dv0 = dv_hi;
    ferr0 = ferr_hi;
    send_bits(8'h3C, 1'b0, 1'b0, 11);
    check("ferr_pulse", ferr_hi - ferr0, 1);
    check("ferr_no_dv", dv_hi - dv0, 0);
    check("ferr_byte_kept", {24'd0, rx.o_RX_Byte}, 32'hFF);
    repeat (220) @(posedge clk);
    #1;
    check("stuck_low_ferrs", {31'd0, (ferr_hi - ferr0) >= 3}, 32'd1);
    check("stuck_low_no_dv", dv_hi - dv0, 0);

    // Reset to clear the stuck-low frame
    rst_n = 1'b0;
    rx.i_RX_Serial = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    check("rst2_byte", {24'd0, rx.o_RX_Byte}, 32'd0);

    // Reset mid data bit 4 of 0x81, then 0x42
    dv0 = dv_hi;
    send_bits(8'h81, 1'b0, 1'b1, 5);
    rx.i_RX_Serial = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_active", {31'd0, rx.o_RX_Active}, 32'd1);
    rst_n = 1'b0;
    rx.i_RX_Serial = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_active", {31'd0, rx.o_RX_Active}, 32'd0);
    check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    check("mid_rst_byte", {24'd0, rx.o_RX_Byte}, 32'd0);
    check("mid_rst_dv", {31'd0, rx.o_RX_DV}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    exp_q.push_back(8'h42);
    send_bits(8'h42, 1'b0, 1'b1, 11);
    idle(5);
    check("post_rst_dv_count", dv_hi - dv0, 1);
    check("post_rst_byte", {24'd0, rx.o_RX_Byte}, 32'h42);
    check("post_rst_queue", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    dv0 = dv_hi;
    exp_q.push_back(8'h07);
    send_bits(8'h07, 1'b1, 1'b1, 11);
    idle(5);
    check("par_ok_dv", dv_hi - dv0, 1);
    check("par_ok_byte", {24'd0, rx.o_RX_Byte}, 32'h07);
    check("par_ok_perr", perr_hi, 0);
    dv0 = dv_hi;
    send_bits(8'h07, 1'b0, 1'b1, 11);
    idle(5);
    check("par_bad_perr", perr_hi, 1);
    check("par_bad_no_dv", dv_hi - dv0, 0);
`else
    check("no_parity_perr", perr_hi, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, giving clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have port i_Clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port i_Rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port i_RX_Serial, input, 1, asynchronous serial line: idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port o_RX_DV, output, 1, one-cycle pulse marking a valid received byte.
REQ-006 SHALL have port o_RX_Byte, output, 8, last received byte.
REQ-007 SHALL have port o_RX_Active, output, 1, high while a frame is being received.
REQ-008 SHALL have port o_RX_Frame_Err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port o_RX_Parity_Err, output, 1, one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-010 SHALL pass i_RX_Serial through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-011 SHALL implement states IDLE, RX_START_BIT, RX_DATA_BITS, RX_PARITY_BIT (macro only), RX_STOP_BIT, CLEANUP; undefined encodings go to IDLE.
REQ-012 IDLE: clock count and bit index held at 0; synchronized line = 0 -> RX_START_BIT and o_RX_Active <= 1.
REQ-013 RX_START_BIT: count 0..H, where H = (CLKS_PER_BIT-1)/2 (integer division); at count H the line is sampled: 0 -> count cleared, RX_DATA_BITS; 1 -> glitch, IDLE with o_RX_Active <= 0 and no pulse output.
REQ-014 RX_DATA_BITS: count 0..CLKS_PER_BIT-1; at count CLKS_PER_BIT-1 the line is stored into byte bit [index], count cleared, index incremented; after index 7 -> next state (parity or stop), index reset to 0.
REQ-015 RX_STOP_BIT: at count CLKS_PER_BIT-1 the line is sampled: 1 -> o_RX_DV <= 1 and o_RX_Byte <= assembled byte; 0 -> o_RX_Frame_Err <= 1, o_RX_Byte unchanged, no o_RX_DV; either case -> CLEANUP, o_RX_Active <= 0.
REQ-016 CLEANUP: one cycle; clears o_RX_DV, o_RX_Frame_Err, o_RX_Parity_Err; -> IDLE.
REQ-017 o_RX_DV, o_RX_Frame_Err and o_RX_Parity_Err SHALL each be high for exactly one cycle per event.
REQ-018 o_RX_Byte SHALL hold its value until the next valid frame completes.
REQ-019 Latency: with edge 0 the first rising edge at which raw i_RX_Serial is sampled low, o_RX_DV SHALL be high during the cycle after edge 3+H+9*CLKS_PER_BIT (+CLKS_PER_BIT with parity).
REQ-020 A start edge arriving during CLEANUP SHALL be detected on the first IDLE cycle, so back-to-back frames with a one-bit stop are received without loss.
REQ-021 A line stuck low after a frame error SHALL re-enter RX_START_BIT and report further frame errors; no lockup.
REQ-022 Clock counter SHALL be 8 bits and never wrap within a state.

Reset
REQ-023 i_Rst_n low at a clock edge SHALL force state IDLE, count 0, index 0, synchronizer flops 1, o_RX_Byte 0x00, and all other outputs 0, overriding any in-progress frame.
REQ-024 After reset release, a partially received frame SHALL be discarded; reception resumes only on the next detected start bit.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: an even-parity bit follows data bit 7 and is sampled in RX_PARITY_BIT at count CLKS_PER_BIT-1; if the XOR of the 8 data bits and the parity bit is 1, o_RX_Parity_Err pulses in CLEANUP alongside the stop-bit result, and o_RX_DV is suppressed for that frame.
REQ-026 Macro undefined: RX_PARITY_BIT is absent, the frame is 8N1, and o_RX_Parity_Err is tied to 0.

Verification (CLKS_PER_BIT=8, H=3)
REQ-027 Send 0xA5 8N1 -> o_RX_DV single pulse at cycle 78 after edge 0, o_RX_Byte=0xA5, no errors.
REQ-028 Send 0x00 then 0xFF back-to-back, 1 stop bit each -> two DV pulses, bytes 0x00 then 0xFF.
REQ-029 Low glitch of 2 cycles on idle line -> returns to IDLE, o_RX_Active drops, no DV or error pulse.
REQ-030 Send 0x3C with stop bit forced 0 -> o_RX_Frame_Err pulse, no DV, o_RX_Byte keeps previous value.
REQ-031 Assert i_Rst_n=0 mid data bit 4 of 0x81, release, then send 0x42 -> only 0x42 is reported, outputs 0 during reset.
REQ-032 With UART_RX_PARITY_EN: 0x07 with parity 1 -> DV, byte 0x07; same byte with parity 0 -> o_RX_Parity_Err pulse, no DV.
